// File: rtl/ip_complex_arb_pkg.sv
// Shared types and defaults for the ip_complex arbiter slice.
// FSM state encoding, default operand widths, grant-id width.
package ip_complex_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_W     = 8;
  localparam int DEF_B_W     = 4;

  localparam int ID_W =
    ($clog2(DEF_NUM_REQ) < 1) ? 1 : $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/ip_complex_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit from ptr up, mod N.
// Ports: req[N], ptr -> grant (one-hot), grant_id, any.
module rr_arbiter
  import ip_complex_arb_pkg::*;
#(
  parameter int N   = DEF_NUM_REQ,
  parameter int IDW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  int          idx;
  logic [N-1:0] req_sh;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    req_sh   = '0;
    for (int k = 0; k < N; k++) begin
      idx    = (int'(ptr) + k) % N;
      req_sh = req >> idx;
      if (!any && req_sh[0]) begin
        any      = 1'b1;
        grant    = N'(1) << idx;
        grant_id = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/ip_complex_arbiter.sv
// Shares one ip_complex between NUM_REQ valid/ready requesters, round-robin,
// with settle delay, ready watchdog and per-requester response channels.
module ip_complex_arbiter
  import ip_complex_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int A_W         = DEF_A_W,
  parameter int B_W         = DEF_B_W,
  parameter int SETTLE_CYC  = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_din_a,
  input  logic [NUM_REQ*B_W-1:0] req_din_b,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [A_W-1:0]         resp_dout_a,
  output logic [B_W-1:0]         resp_dout_b,
  output logic                   resp_timeout,
  output logic [A_W-1:0]         ip_din_a,
  output logic [B_W-1:0]         ip_din_b,
  input  logic [A_W-1:0]         ip_dout_a,
  input  logic [B_W-1:0]         ip_dout_b,
  input  logic                   ip_ready,
  output logic                   busy
);

  localparam int IDW =
    ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);
  localparam int CMAX =
    (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W =
    ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0]   ID_LAST  = IDW'(NUM_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [A_W-1:0]   ip_a_q, ip_a_d;
  logic [B_W-1:0]   ip_b_q, ip_b_d;
  logic [A_W-1:0]   res_a_q, res_a_d;
  logic [B_W-1:0]   res_b_q, res_b_d;
  logic             to_q, to_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic [NUM_REQ-1:0] id_oh;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr (
    .req      (req_valid),
    .ptr      (rr_q),
    .grant    (gnt),
    .grant_id (gnt_id),
    .any      (gnt_any)
  );

  assign id_oh = NUM_REQ'(1) << id_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    rr_d       = rr_q;
    ip_a_d     = ip_a_q;
    ip_b_d     = ip_b_q;
    res_a_d    = res_a_q;
    res_b_d    = res_b_q;
    to_d       = to_q;
    req_ready  = '0;
    resp_valid = '0;
    unique case (state_q)
      ST_IDLE: begin
        // The grant is offered only while out of reset so nothing
        // is handshaken during a reset cycle.
        if (gnt_any && rst_n) begin
          req_ready = gnt;
          ip_a_d    = req_din_a[gnt_id*A_W +: A_W];
          ip_b_d    = req_din_b[gnt_id*B_W +: B_W];
          id_d      = gnt_id;
          rr_d      = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
          cnt_d     = '0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // ip_ready is ignored here: it may still be high from the last op.
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (ip_ready) begin
          res_a_d = ip_dout_a;
          res_b_d = ip_dout_b;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          res_a_d = '0;
          res_b_d = '0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = rst_n ? id_oh : '0;
        if (|(resp_ready & id_oh)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      ip_a_q  <= '0;
      ip_b_q  <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      ip_a_q  <= ip_a_d;
      ip_b_q  <= ip_b_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
      to_q    <= to_d;
    end
  end

  assign ip_din_a     = ip_a_q;
  assign ip_din_b     = ip_b_q;
  assign resp_dout_a  = res_a_q;
  assign resp_dout_b  = res_b_q;
  assign resp_timeout = to_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ip_complex_arbiter.sv
// Directed scoreboard bench for ip_complex_arbiter.
// Bench models the IP (nibble-swap A, invert B) with a controllable ready.
module tb_ip_complex_arbiter;

  localparam int N = 4;
  localparam int S = 1;
  localparam int T = 16;

  localparam int M_DLY   = 0;
  localparam int M_NONE  = 1;
  localparam int M_STUCK = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*8-1:0] req_din_a;
  logic [N*4-1:0] req_din_b;
  logic [N-1:0] resp_valid;
  logic [N-1:0] resp_ready;
  logic [7:0]   resp_dout_a;
  logic [3:0]   resp_dout_b;
  logic         resp_timeout;
  logic [7:0]   ip_din_a;
  logic [3:0]   ip_din_b;
  logic [7:0]   ip_dout_a;
  logic [3:0]   ip_dout_b;
  logic         ip_ready;
  logic         busy;

  logic [7:0] op_a [N];
  logic [3:0] op_b [N];

  int mode = M_DLY;
  int kdel = 0;
  int acc_cyc = 0;
  int cyc = 0;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [3:0] b;
    logic       to;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  always #5 clk = ~clk;

  assign req_din_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_din_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  assign ip_dout_a = {ip_din_a[3:0], ip_din_a[7:4]};
  assign ip_dout_b = ~ip_din_b;
  assign ip_ready  = (mode == M_STUCK) ||
                     (mode == M_DLY && acc_cyc >= S + 1 + kdel);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|(req_valid & req_ready)) acc_cyc <= 1;
    else if (acc_cyc < 1000)      acc_cyc <= acc_cyc + 1;
  end

  ip_complex_arbiter #(
    .NUM_REQ     (N),
    .A_W         (8),
    .B_W         (4),
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_din_a    (req_din_a),
    .req_din_b    (req_din_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_dout_a  (resp_dout_a),
    .resp_dout_b  (resp_dout_b),
    .resp_timeout (resp_timeout),
    .ip_din_a     (ip_din_a),
    .ip_din_b     (ip_din_b),
    .ip_dout_a    (ip_dout_a),
    .ip_dout_b    (ip_dout_b),
    .ip_ready     (ip_ready),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input int id);
    exp_t e;
    e.id  = id;
    e.acc = 0;
    if (mode == M_NONE) begin
      e.a   = 8'h00;
      e.b   = 4'h0;
      e.to  = 1'b1;
      // watchdog fires in the TIMEOUT_CYC-th WAIT cycle (k = T-1)
      e.lat = S + (T - 1) + 1;
    end else begin
      e.a   = {op_a[id][3:0], op_a[id][7:4]};
      e.b   = ~op_b[id];
      e.to  = 1'b0;
      e.lat = (mode == M_STUCK) ? S + 1 : S + kdel + 1;
    end
    return e;
  endfunction

  // Waits for a grant, checks it, records the expected response,
  // returns at the negedge one cycle after the accept edge.
  task automatic grab(input int id);
    int   t;
    exp_t e;
    t = 0;
    #1;
    while (req_ready == '0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("grant", 32'(req_ready), 32'(1 << id));
    if (req_ready != '0) begin
      e     = mk(id);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_req(input int id, input logic [7:0] a,
                        input logic [3:0] b);
    op_a[id]      = a;
    op_b[id]      = b;
    req_valid[id] = 1'b1;
    grab(id);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int   t;
    exp_t e;
    t = 0;
    while (resp_valid == '0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_seen"}, 32'(resp_valid != '0), 32'd1);
    if (resp_valid != '0 && sb.size() > 0) begin
      e = sb.pop_front();
      last_e = e;
      chk({tag, "_valid"}, 32'(resp_valid), 32'(1 << e.id));
      chk({tag, "_a"}, 32'(resp_dout_a), 32'(e.a));
      chk({tag, "_b"}, 32'(resp_dout_b), 32'(e.b));
      chk({tag, "_to"}, 32'(resp_timeout), 32'(e.to));
      chk({tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    bit saw;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 8'h10 * i[7:0] + 8'h01;
      op_b[i] = 4'(i + 5);
    end
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = '1;

    // reset with all requesters valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_ip_din_a", 32'(ip_din_a), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    @(negedge clk);

    // single request, ready 2 cycles into WAIT
    mode = M_DLY;
    kdel = 2;
    do_req(2, 8'hA5, 4'h3);
    chk("single_ip_din_a", 32'(ip_din_a), 32'hA5);
    chk("single_ip_din_b", 32'(ip_din_b), 32'h3);
    chk("single_busy", 32'(busy), 32'd1);
    wait_resp("single");
    chk("single_a_lit", 32'(resp_dout_a), 32'h5A);
    chk("single_b_lit", 32'(resp_dout_b), 32'hC);

    // round-robin from a fresh pointer
    do_reset(2);
    kdel = 0;
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      grab(g % N);
      if (g == 4) req_valid = 4'b0011;
      wait_resp("rr");
    end
    // pointer is now past 0: newly raised 1 beats pending 0
    grab(1);
    req_valid = '0;
    wait_resp("rr_next");

    // watchdog timeout, then a normal op
    mode = M_NONE;
    do_req(1, 8'h3C, 4'h9);
    wait_resp("tmo");
    mode = M_DLY;
    kdel = 1;
    do_req(3, 8'hE1, 4'h6);
    wait_resp("post_tmo");

    // response backpressure; other resp_ready bits must be ignored
    kdel = 0;
    resp_ready = 4'b1110;
    do_req(0, 8'h77, 4'h2);
    wait_resp("bp");
    req_valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'b0001);
      chk("bp_hold_a", 32'(resp_dout_a), 32'(last_e.a));
      chk("bp_no_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = '1;
    grab(2);
    req_valid = '0;
    wait_resp("bp_next");

    // stale ready held high across ops
    mode = M_STUCK;
    do_req(1, 8'h12, 4'h4);
    wait_resp("stuck1");
    do_req(2, 8'h9B, 4'hD);
    wait_resp("stuck2");

    // reset while in WAIT discards the op and resets the pointer
    mode = M_NONE;
    do_req(2, 8'h44, 4'h1);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset(1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (resp_valid != '0) saw = 1'b1;
    end
    chk("mid_rst_no_resp", 32'(saw), 32'd0);
    mode = M_DLY;
    kdel = 0;
    req_valid = 4'b1001;
    grab(0);
    req_valid = '0;
    wait_resp("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
